// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT sequencing, prioritised redirects and a valid/ready fetch handshake.
// Define PC_GEN_MISALIGN_EN to reject misaligned redirect targets instead of silently clearing bits [1:0].
module pc_gen #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_VEC = '0,
    parameter int                NREDIR    = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREDIR-1:0]        io_redir_valid,
    input  logic [NREDIR*XLEN-1:0]   io_redir_target,
    input  logic                     io_stall_en,
    input  logic                     io_halt,
    input  logic                     io_pc_ready,
    output logic                     io_pc_valid,
    output logic [XLEN-1:0]          io_pc,
    output logic [NREDIR-1:0]        io_redir_taken,
    output logic                     io_misalign,
    output logic [XLEN-1:0]          io_misalign_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              redir_any;
    logic [XLEN-1:0]   sel_target;
    logic [XLEN-1:0]   load_target;
    logic              reject;
    logic              fire;

    // Scan from the highest channel down so the lowest asserted index wins.
    always_comb begin
        io_redir_taken = '0;
        sel_target     = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (io_redir_valid[i]) begin
                io_redir_taken    = '0;
                io_redir_taken[i] = 1'b1;
                sel_target        = io_redir_target[i*XLEN +: XLEN];
            end
        end
    end

    assign redir_any = |io_redir_valid;

`ifdef PC_GEN_MISALIGN_EN
    assign reject      = redir_any && (sel_target[1:0] != 2'b00);
    assign load_target = sel_target;
`else
    assign reject      = 1'b0;
    assign load_target = sel_target & ~XLEN'(3);
`endif

    assign fire = io_pc_valid && io_pc_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redir_any) begin
            state_next = reject ? HALT : RUN;
        end else begin
            case (state)
                BOOT:    state_next = RUN;
                RUN:     state_next = io_halt ? HALT : RUN;
                HALT:    state_next = HALT;
                default: state_next = BOOT;
            endcase
        end
    end

    always_comb begin
        io_pc_valid = (state == RUN) && !io_stall_en && !reset;
    end

    // A rejected redirect freezes the PC; otherwise a redirect beats the sequential advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_pc <= RESET_VEC;
        end else if (redir_any) begin
            if (!reject) begin
                io_pc <= load_target;
            end
        end else if (fire) begin
            io_pc <= io_pc + XLEN'(4);
        end
    end

`ifdef PC_GEN_MISALIGN_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            io_misalign      <= 1'b0;
            io_misalign_addr <= '0;
        end else begin
            io_misalign <= reject;
            if (reject) begin
                io_misalign_addr <= sel_target;
            end
        end
    end
`else
    assign io_misalign      = 1'b0;
    assign io_misalign_addr = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen (XLEN=32, NREDIR=3, RESET_VEC=0x100).
// Misalignment expectations follow PC_GEN_MISALIGN_EN when it is defined.
module tb_pc_gen;

    logic          clock;
    logic          reset;
    logic [2:0]    redir_valid;
    logic [95:0]   redir_target;
    logic          stall_en;
    logic          halt;
    logic          pc_ready;
    logic          pc_valid;
    logic [31:0]   pc;
    logic [2:0]    redir_taken;
    logic          misalign;
    logic [31:0]   misalign_addr;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [2:0]  rv;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic        stall;
        logic        hlt;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_taken;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[18];

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h100),
        .NREDIR    (3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_redir_valid   (redir_valid),
        .io_redir_target  (redir_target),
        .io_stall_en      (stall_en),
        .io_halt          (halt),
        .io_pc_ready      (pc_ready),
        .io_pc_valid      (pc_valid),
        .io_pc            (pc),
        .io_redir_taken   (redir_taken),
        .io_misalign      (misalign),
        .io_misalign_addr (misalign_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] rv, input logic [31:0] t0, input logic [31:0] t1,
                                 input logic [31:0] t2, input logic stall, input logic hlt, input logic rdy);
        redir_valid  = rv;
        redir_target = {t2, t1, t0};
        stall_en     = stall;
        halt         = hlt;
        pc_ready     = rdy;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // rv, t0, t1, t2, stall, halt, ready, exp_valid, exp_taken, exp_pc (after edge)
        vecs[0]  = '{3'b110, 32'h0,        32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h200};
        vecs[1]  = '{3'b111, 32'h10,       32'h200, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h10};
        vecs[2]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h10};
        vecs[3]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h10};
        vecs[4]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h14};
        vecs[5]  = '{3'b100, 32'h0,        32'h0,   32'h40,  1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 32'h40};
        vecs[6]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h40};
        vecs[7]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h40};
        vecs[8]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h40};
        vecs[9]  = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h40};
        vecs[10] = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h40};
        vecs[11] = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h40};
        vecs[12] = '{3'b010, 32'h0,        32'h80,  32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h80};
        vecs[13] = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h84};
        vecs[14] = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h84};
        vecs[15] = '{3'b001, 32'hFFFFFFFC, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFC};
        vecs[16] = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0};
        vecs[17] = '{3'b000, 32'h0,        32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h4};

        reset = 1'b1;
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("reset_pc", pc, 32'h100);
        checkOutput("reset_valid", pc_valid, 1'b0);
        checkOutput("reset_misalign", misalign, 1'b0);
        checkOutput("reset_misalign_addr", misalign_addr, 32'h0);

        reset = 1'b0;
        pc_ready = 1'b1;
        #2;
        checkOutput("boot_valid", pc_valid, 1'b0);
        tick();
        checkOutput("boot_pc_hold", pc, 32'h100);
        checkOutput("run_valid", pc_valid, 1'b1);
        tick();
        checkOutput("run_pc_104", pc, 32'h104);
        tick();
        checkOutput("run_pc_108", pc, 32'h108);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].t0, vecs[i].t1, vecs[i].t2,
                          vecs[i].stall, vecs[i].hlt, vecs[i].rdy);
            #2;
            checkOutput($sformatf("vec%0d_valid", i), pc_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_taken", i), redir_taken, vecs[i].exp_taken);
            tick();
            checkOutput($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_misalign", i), misalign, 1'b0);
        end

        // Misaligned redirect from a known PC of 0x100.
        applyStimulus(3'b001, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mis_setup_pc", pc, 32'h100);
        applyStimulus(3'b010, 32'h0, 32'h102, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("mis_taken", redir_taken, 3'b010);
        tick();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("mis_pc", pc, 32'h100);
`ifdef PC_GEN_MISALIGN_EN
        checkOutput("mis_pulse", misalign, 1'b1);
        checkOutput("mis_addr", misalign_addr, 32'h102);
        checkOutput("mis_halt_valid", pc_valid, 1'b0);
        tick();
        checkOutput("mis_pulse_end", misalign, 1'b0);
        checkOutput("mis_addr_hold", misalign_addr, 32'h102);
        checkOutput("mis_pc_hold", pc, 32'h100);
`else
        checkOutput("mis_pulse", misalign, 1'b0);
        checkOutput("mis_addr", misalign_addr, 32'h0);
        checkOutput("mis_run_valid", pc_valid, 1'b1);
`endif

        // Reset wins over a simultaneous redirect; a redirect in BOOT is honoured.
        reset = 1'b1;
        applyStimulus(3'b001, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("rst_valid_low", pc_valid, 1'b0);
        checkOutput("rst_taken", redir_taken, 3'b001);
        tick();
        checkOutput("rst_override_pc", pc, 32'h100);
        reset = 1'b0;
        applyStimulus(3'b001, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("boot_redir_valid", pc_valid, 1'b0);
        tick();
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("boot_redir_pc", pc, 32'h300);
        checkOutput("boot_redir_run", pc_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width in bits, legal range 16..64.
REQ-002 SHALL have parameter RESET_VEC, default 0: PC value loaded at reset; bits [1:0] are 00.
REQ-003 SHALL have parameter NREDIR, default 3: number of redirect channels, legal range 1..4; channel 0 has the highest priority.
REQ-004 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port io_redir_valid  input  NREDIR  per-channel redirect request.
REQ-007 SHALL have port io_redir_target  input  NREDIR*XLEN  target of channel i at bits [i*XLEN +: XLEN].
REQ-008 SHALL have port io_stall_en  input  1  hold the PC, no sequential advance.
REQ-009 SHALL have port io_halt  input  1  request entry to the HALT state.
REQ-010 SHALL have port io_pc_ready  input  1  fetch accepts the current PC.
REQ-011 SHALL have port io_pc_valid  output  1  the current PC is offered to fetch.
REQ-012 SHALL have port io_pc  output  XLEN  current PC register.
REQ-013 SHALL have port io_redir_taken  output  NREDIR  one-hot winning channel; all zero when no channel requests.
REQ-014 SHALL have port io_misalign  output  1  one-cycle pulse on a rejected misaligned redirect.
REQ-015 SHALL have port io_misalign_addr  output  XLEN  registered address of the last rejected target.

Function
REQ-016 SHALL implement states BOOT, RUN and HALT.
REQ-017 SHALL leave BOOT for RUN unconditionally after one cycle.
REQ-018 SHALL drive io_pc_valid = (state==RUN) & ~io_stall_en, combinationally.
REQ-019 SHALL select the lowest-indexed asserted channel; io_redir_taken reflects that choice in the same cycle, combinationally.
REQ-020 SHALL, on any selected redirect in any state, load io_pc with the selected target on the next edge and enter RUN, independent of io_stall_en, io_pc_ready and io_halt.
REQ-021 SHALL, in RUN with no redirect, add 4 to io_pc when io_pc_valid and io_pc_ready are both 1; otherwise io_pc holds.
REQ-022 SHALL compute the increment modulo 2^XLEN (all-ones-minus-3 wraps to 0), with no flag raised.
REQ-023 SHALL, in RUN with no redirect and io_halt=1, enter HALT with io_pc held; a same-cycle fetch handshake still advances io_pc by 4 first.
REQ-024 SHALL, in HALT, ignore io_halt, io_stall_en and io_pc_ready; only a redirect leaves HALT.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set state=BOOT, io_pc=RESET_VEC, io_misalign=0 and io_misalign_addr=0; reset overrides every other input.
REQ-026 SHALL hold io_pc_valid=0 and io_redir_taken driven only by its inputs during and after reset; a redirect during the BOOT cycle is honoured per REQ-020.

Configuration
REQ-027 SHALL, with macro PC_GEN_MISALIGN_EN defined, reject a selected target whose bits [1:0] are not 00.
  - io_pc holds and state goes to HALT.
  - io_misalign pulses 1 for exactly one cycle.
  - io_misalign_addr captures the rejected target.
  - io_redir_taken still reports the winning channel.
REQ-028 SHALL, without PC_GEN_MISALIGN_EN, clear target bits [1:0] to 00 on load, and tie io_misalign and io_misalign_addr to 0.

Verification
REQ-029 SHALL cover reset: reset 1 then released, RESET_VEC=0x100 -> io_pc=0x100 and valid=0 for one cycle, then valid=1; with ready=1, io_pc goes 0x104, 0x108.
REQ-030 SHALL cover redirect priority: valid=3'b110 with targets ch1=0x200, ch2=0x300 -> io_redir_taken=3'b010 and next io_pc=0x200.
REQ-031 SHALL cover stall and backpressure: stall=1 -> io_pc held and valid=0; stall=0 with ready=0 -> io_pc held; ready=1 -> +4; a redirect to 0x40 while stall=1 -> io_pc=0x40.
REQ-032 SHALL cover halt: halt=1 in RUN -> next cycle valid=0 and io_pc frozen for 5 cycles; redirect to 0x80 -> RUN with io_pc=0x80.
REQ-033 SHALL cover wrap: io_pc=0xFFFFFFFC with ready=1 -> io_pc=0x00000000.
REQ-034 SHALL cover misalignment: redirect to 0x102.
  - With PC_GEN_MISALIGN_EN: io_misalign pulses once, io_misalign_addr=0x102, state HALT, io_pc unchanged.
  - Without PC_GEN_MISALIGN_EN: io_pc=0x100.
